readout_deserializer: RTL and testbench

- Captures the serial readout bitstream returned by the T3MAPS prototype on data_in and packs it into bytes.
- Runs in the 5 MHz domain. Its byte writes go into the readout FIFO that uartControl drains to the UART.
- Sits directly upstream of that FIFO, in place of raw data_in sampling.
- A capture is started by a one-cycle pulse from the command path once a readout command has been shifted out on cmd.

---
 rtl/t3maps_daq_pkg.sv | 16 +
 rtl/readout_deserializer_byte_packer.sv | 71 +++++++
 rtl/readout_deserializer.sv | 146 ++++++++++++++
 tb/tb_readout_deserializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/t3maps_daq_pkg.sv
// Shared types and defaults for the T3MAPS readout data-acquisition path.
package t3maps_daq_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/readout_deserializer_byte_packer.sv
// Packs serial bits MSB-first into bytes and registers each completed or
// flushed byte onto the FIFO write port, dropping it when the FIFO is full.
module byte_packer
  import t3maps_daq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_i,
  input  logic              bit_i,
  input  logic              last_i,
  input  logic              full_i,
  output logic              emit_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              wr_o
);

  // The 8th bit never lands in the register; it goes straight into the byte.
  logic [BYTE_W-2:0] sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              wr_q, wr_d;
  logic [BYTE_W-1:0] sr_next_s;
  logic [3:0]        nbits_s;
  logic [3:0]        pad_s;

  // Shift, byte-complete detection and left-aligned output staging.
  always_comb begin
    sr_next_s = {sr_q, bit_i};
    nbits_s   = {1'b0, bit_cnt_q} + 4'd1;
    pad_s     = 4'd8 - nbits_s;
    emit_o    = sample_i && ((bit_cnt_q == 3'd7) || last_i);
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    wr_d      = 1'b0;
    if (emit_o) begin
      sr_d      = '0;
      bit_cnt_d = 3'd0;
      if (!full_i) begin
        byte_d = sr_next_s << pad_s;
        wr_d   = 1'b1;
      end else begin
        byte_d = byte_q;
      end
    end else if (sample_i) begin
      sr_d      = sr_next_s[BYTE_W-2:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      sr_d = sr_q;
    end
  end

  // Packer state and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
      byte_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      wr_q      <= wr_d;
    end
  end

  assign byte_o = byte_q;
  assign wr_o   = wr_q;

endmodule

// File: rtl/readout_deserializer.sv
// Captures the T3MAPS serial readout stream after a start pulse and writes it
// as bytes into the readout FIFO; the chip cannot be stalled, so full drops.
module readout_deserializer
  import t3maps_daq_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk_5,
  input  logic              Reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic              data_in,
  input  logic              fifo_full,
  output logic [BYTE_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int DLY_W = 8;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic              partial_q, partial_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic              sample_s;
  logic              last_s;
  logic              emit_s;

  assign sample_s = (state_q == ST_SHIFT);
  assign last_s   = sample_s && (rem_q == CNT_W'(1));

  // State and counter registers.
  always_ff @(posedge clk_5) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      delay_q      <= '0;
      partial_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      delay_q      <= delay_d;
      partial_q    <= partial_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Next state; ARM spans LATENCY-1 cycles so SHIFT samples on edge start+LATENCY.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    delay_d   = delay_q;
    partial_d = partial_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d     = num_bits;
          partial_d = |num_bits[2:0];
          if (num_bits == '0) begin
            state_d = ST_DONE;
          end else if (LATENCY <= 1) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_ARM;
            delay_d = DLY_W'(LATENCY - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (delay_q <= 8'd1) begin
          state_d = ST_SHIFT;
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        rem_d = rem_q - CNT_W'(1);
        if (last_s) begin
          state_d = partial_q ? ST_FLUSH : ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output staging: status flags and the saturating written-byte count.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    if ((state_q == ST_IDLE) && start) begin
      overflow_d   = 1'b0;
      byte_count_d = '0;
    end else if (emit_s) begin
      if (fifo_full) begin
        overflow_d = 1'b1;
      end else if (byte_count_q != {CNT_W{1'b1}}) begin
        byte_count_d = byte_count_q + CNT_W'(1);
      end else begin
        byte_count_d = byte_count_q;
      end
    end else begin
      overflow_d = overflow_q;
    end
  end

  byte_packer u_packer (
    .clk_i    (clk_5),
    .rst_ni   (Reset),
    .sample_i (sample_s),
    .bit_i    (data_in),
    .last_i   (last_s),
    .full_i   (fifo_full),
    .emit_o   (emit_s),
    .byte_o   (fifo_din),
    .wr_o     (fifo_wr_en)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_readout_deserializer.sv
// Directed bench: a per-scenario schedule of inputs, a bit-index model of the
// expected outputs, per-cycle comparison, and literal checks of the byte log.
module tb_readout_deserializer;

  localparam int LAT  = 2;
  localparam int CW   = 16;
  localparam int MAXC = 64;

  logic          clk_5 = 1'b0;
  logic          Reset, start, data_in, fifo_full;
  logic [CW-1:0] num_bits;
  logic [7:0]    fifo_din;
  logic          fifo_wr_en, busy, done, overflow;
  logic [CW-1:0] byte_count;

  readout_deserializer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk_5(clk_5), .Reset(Reset), .start(start), .num_bits(num_bits),
    .data_in(data_in), .fifo_full(fifo_full), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done), .overflow(overflow),
    .byte_count(byte_count)
  );

  always #5 clk_5 = ~clk_5;

  // Schedule: inputs applied before edge n; expectations hold after edge n.
  logic          in_rst[MAXC], in_start[MAXC], in_data[MAXC], in_full[MAXC];
  logic [CW-1:0] in_num[MAXC];
  logic          clr[MAXC], wrv[MAXC], drop[MAXC];
  logic [7:0]    wbyte[MAXC];
  logic          exp_wr[MAXC], exp_busy[MAXC], exp_done[MAXC], exp_ovf[MAXC];
  logic [7:0]    exp_din[MAXC];
  logic [CW-1:0] exp_bc[MAXC];
  logic          act_ovf[MAXC];
  logic [CW-1:0] act_bc[MAXC];
  logic [7:0]    wr_log[$];
  int            done_at, busy_cnt;
  int            vecs = 0;
  int            errs = 0;

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc %0d: got %0h want %0h", name, n, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int n = 0; n < MAXC; n++) begin
      in_rst[n] = 1'b0; in_start[n] = 1'b0; in_data[n] = 1'b0; in_full[n] = 1'b0;
      in_num[n] = '0; clr[n] = 1'b0; wrv[n] = 1'b0; drop[n] = 1'b0; wbyte[n] = 8'h00;
      exp_wr[n] = 1'b0; exp_busy[n] = 1'b0; exp_done[n] = 1'b0;
    end
    in_rst[0] = 1'b1;
  endtask

  task automatic put_bits(input int e0, input logic [7:0] v, input int nb);
    for (int i = 0; i < nb; i++) in_data[e0 + i] = v[nb - 1 - i];
  endtask

  task automatic start_at(input int s, input int nb);
    in_start[s] = 1'b1;
    in_num[s]   = CW'(nb);
  endtask

  // Capture model: bit k is sampled on edge s+LAT+k; a byte is written (or
  // dropped if full) right after its last bit; an unaligned tail takes one
  // extra FLUSH cycle before done. Events at or after 'stop' are aborted.
  task automatic model_capture(input int s, input int nb, input int stop);
    int last_e, done_i, hi, e;
    logic [7:0] b;
    if (s < stop) begin
      clr[s] = 1'b1;
      if (nb == 0) begin
        done_i = s;
      end else begin
        last_e = s + LAT + nb - 1;
        done_i = (nb % 8 == 0) ? last_e : last_e + 1;
        for (int j = 0; j * 8 < nb; j++) begin
          hi = (j * 8 + 7 < nb) ? j * 8 + 7 : nb - 1;
          b = 8'h00;
          for (int k = j * 8; k <= hi; k++) b[7 - (k - j * 8)] = in_data[s + LAT + k];
          e = s + LAT + hi;
          if (e < stop) begin
            if (in_full[e]) drop[e] = 1'b1;
            else begin wrv[e] = 1'b1; wbyte[e] = b; end
          end
        end
      end
      for (int n = s; n <= done_i && n < stop; n++) exp_busy[n] = 1'b1;
      if (done_i < stop) exp_done[done_i] = 1'b1;
    end
  endtask

  // Fold events into the persistent outputs (din, byte_count, overflow).
  task automatic finalize(input int len);
    logic [7:0] d;
    logic [CW-1:0] bc;
    logic ov;
    d = 8'h00; bc = '0; ov = 1'b0;
    for (int n = 0; n < len; n++) begin
      if (in_rst[n]) begin
        d = 8'h00; bc = '0; ov = 1'b0;
      end else begin
        if (clr[n]) begin bc = '0; ov = 1'b0; end
        if (wrv[n]) begin
          d = wbyte[n];
          if (bc != {CW{1'b1}}) bc = bc + 16'd1;
        end
        if (drop[n]) ov = 1'b1;
      end
      exp_wr[n] = wrv[n] && !in_rst[n];
      exp_din[n] = d; exp_bc[n] = bc; exp_ovf[n] = ov;
    end
  endtask

  task automatic run(input int len);
    finalize(len);
    wr_log.delete();
    done_at = -1; busy_cnt = 0;
    for (int n = 0; n < len; n++) begin
      Reset = ~in_rst[n]; start = in_start[n]; num_bits = in_num[n];
      data_in = in_data[n]; fifo_full = in_full[n];
      @(posedge clk_5);
      @(negedge clk_5);
      chk("wr_en", n, {31'd0, fifo_wr_en}, {31'd0, exp_wr[n]});
      chk("din", n, {24'd0, fifo_din}, {24'd0, exp_din[n]});
      chk("busy", n, {31'd0, busy}, {31'd0, exp_busy[n]});
      chk("done", n, {31'd0, done}, {31'd0, exp_done[n]});
      chk("overflow", n, {31'd0, overflow}, {31'd0, exp_ovf[n]});
      chk("byte_count", n, {16'd0, byte_count}, {16'd0, exp_bc[n]});
      if (fifo_wr_en) wr_log.push_back(fifo_din);
      if (done) done_at = n;
      if (busy) busy_cnt++;
      act_ovf[n] = overflow; act_bc[n] = byte_count;
    end
    start = 1'b0;
  endtask

  task automatic chk_log(input string name, input logic [7:0] b0, input logic [7:0] b1, input int cnt);
    chk({name, "_nwr"}, 0, wr_log.size(), cnt);
    if (wr_log.size() > 0) chk({name, "_b0"}, 0, {24'd0, wr_log[0]}, {24'd0, b0});
    if (wr_log.size() > 1) chk({name, "_b1"}, 1, {24'd0, wr_log[1]}, {24'd0, b1});
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; num_bits = '0; data_in = 1'b0; fifo_full = 1'b0;

    // Full bytes: 0xA5, 0x3C.
    clear_sched();
    start_at(2, 16); put_bits(4, 8'hA5, 8); put_bits(12, 8'h3C, 8);
    model_capture(2, 16, MAXC);
    run(24);
    chk_log("full", 8'hA5, 8'h3C, 2);
    chk("full_bc", 23, {16'd0, act_bc[23]}, 32'd2);
    chk("full_done_at", 0, done_at, 19);

    // Partial byte: 0xB6 then flushed 1101 -> 0xD0.
    clear_sched();
    start_at(2, 12); put_bits(4, 8'hB6, 8); put_bits(12, 8'h0D, 4);
    model_capture(2, 12, MAXC);
    run(22);
    chk_log("partial", 8'hB6, 8'hD0, 2);
    chk("partial_bc", 21, {16'd0, act_bc[21]}, 32'd2);

    // Zero length.
    clear_sched();
    start_at(2, 0);
    model_capture(2, 0, MAXC);
    run(8);
    chk("zero_nwr", 0, wr_log.size(), 0);
    chk("zero_done_at", 0, done_at, 2);
    chk("zero_busy_cycles", 0, busy_cnt, 1);

    // Overflow on the second byte, then a new start clears it.
    clear_sched();
    start_at(2, 24); put_bits(4, 8'h81, 8); put_bits(12, 8'h7E, 8); put_bits(20, 8'hC9, 8);
    in_full[19] = 1'b1;
    model_capture(2, 24, MAXC);
    start_at(30, 0);
    model_capture(30, 0, MAXC);
    run(34);
    chk_log("ovf", 8'h81, 8'hC9, 2);
    chk("ovf_sticky", 29, {31'd0, act_ovf[29]}, 32'd1);
    chk("ovf_bc", 29, {16'd0, act_bc[29]}, 32'd2);
    chk("ovf_cleared", 31, {31'd0, act_ovf[31]}, 32'd0);

    // Start during capture is ignored: 10 bits -> 0xE7, 0x40.
    clear_sched();
    start_at(2, 10); put_bits(4, 8'hE7, 8); put_bits(12, 8'h01, 2);
    start_at(7, 3);
    model_capture(2, 10, MAXC);
    run(20);
    chk_log("busy_start", 8'hE7, 8'h40, 2);

    // Reset after 5 bits aborts; a fresh 8-bit capture then writes 0xC3.
    clear_sched();
    start_at(2, 16); put_bits(4, 8'hFF, 8);
    in_rst[9] = 1'b1;
    model_capture(2, 16, 9);
    start_at(12, 8); put_bits(14, 8'hC3, 8);
    model_capture(12, 8, MAXC);
    run(26);
    chk_log("rst_abort", 8'hC3, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
